// File: rtl/irq_pkg.sv
// Shared types, limits and bit-count helpers for the interrupt pending latch.
package irq_pkg;

  localparam int IRQ_N    = 8;
  localparam int IRQ_ID_W = 3;

  typedef logic [IRQ_N-1:0]    irq_vec_t;
  typedef logic [IRQ_ID_W-1:0] irq_id_t;

  localparam logic [7:0] OVR_MAX = 8'hFF;

  function automatic logic [3:0] pop8(input irq_vec_t v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < IRQ_N; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {5'b00000, b};
    if (sum > {1'b0, OVR_MAX}) begin
      return OVR_MAX;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

// File: rtl/irq_edge_det.sv
// Rising-edge detector for the request lines; IRQ_SYNC_EN adds a 2-flop
// synchronizer in front of the edge detect.
module irq_edge_det
  import irq_pkg::*;
#(
  parameter int W = IRQ_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] s_s;
  logic [W-1:0] s_prev_r;

`ifdef IRQ_SYNC_EN
  logic [W-1:0] sync1_r;
  logic [W-1:0] sync2_r;

  // two-stage synchronizer for asynchronous request lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {W{1'b0}};
      sync2_r <= {W{1'b0}};
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  assign s_s = sync2_r;
`else
  assign s_s = din;
`endif

  // previous sample; reset to 0 so a line held high through reset counts once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev_r <= {W{1'b0}};
    end else begin
      s_prev_r <= s_s;
    end
  end

  assign rise = s_s & ~s_prev_r;

endmodule

// File: rtl/irq_pend_latch.sv
// Sticky pending latch with mask, ack-by-index and saturating overrun count,
// feeding the 8-to-3 priority encoder. Optional macro: IRQ_SYNC_EN.
module irq_pend_latch
  import irq_pkg::*;
#(
  parameter int N    = IRQ_N,
  parameter int ID_W = IRQ_ID_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    irq_in,
  input  logic            mask_wr,
  input  logic [N-1:0]    mask_in,
  input  logic            ack,
  input  logic [ID_W-1:0] ack_id,
  output logic [N-1:0]    pend_out,
  output logic            irq_valid,
  output logic [N-1:0]    mask_q,
  output logic [7:0]      ovr_cnt
);

  logic [N-1:0] edge_s;
  logic [N-1:0] ack_hit_s;
  logic [N-1:0] ovr_hit_s;
  logic [N-1:0] pend_nxt_s;
  logic [N-1:0] mask_nxt_s;
  logic [N-1:0] vis_nxt_s;
  logic [7:0]   ovr_nxt_s;

  logic [N-1:0] pend_r;
  logic [N-1:0] mask_r;
  logic [N-1:0] pend_out_r;
  logic         irq_valid_r;
  logic [7:0]   ovr_cnt_r;

  irq_edge_det #(.W(N)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (irq_in),
    .rise  (edge_s)
  );

  // one-hot decode of the acknowledge index
  always_comb begin
    ack_hit_s = {N{1'b0}};
    if (ack) begin
      ack_hit_s[ack_id] = 1'b1;
    end else begin
      ack_hit_s = {N{1'b0}};
    end
  end

  // next mask value; a write lands together with any ack this cycle
  always_comb begin
    mask_nxt_s = mask_r;
    if (mask_wr) begin
      mask_nxt_s = mask_in;
    end else begin
      mask_nxt_s = mask_r;
    end
  end

  // set wins over ack; an edge on a pending, un-acked bit is a lost event
  assign pend_nxt_s = (pend_r & ~ack_hit_s) | edge_s;
  assign ovr_hit_s  = edge_s & pend_r & ~ack_hit_s;
  assign vis_nxt_s  = pend_nxt_s & ~mask_nxt_s;
  assign ovr_nxt_s  = sat_add8(ovr_cnt_r, pop8(ovr_hit_s));

  // pending, mask, overrun and registered encoder-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r      <= {N{1'b0}};
      mask_r      <= {N{1'b0}};
      pend_out_r  <= {N{1'b0}};
      irq_valid_r <= 1'b0;
      ovr_cnt_r   <= 8'd0;
    end else begin
      pend_r      <= pend_nxt_s;
      mask_r      <= mask_nxt_s;
      pend_out_r  <= vis_nxt_s;
      irq_valid_r <= |vis_nxt_s;
      ovr_cnt_r   <= ovr_nxt_s;
    end
  end

  assign pend_out  = pend_out_r;
  assign irq_valid = irq_valid_r;
  assign mask_q    = mask_r;
  assign ovr_cnt   = ovr_cnt_r;

endmodule

// File: tb/tb_irq_pend_latch.sv
// Self-checking bench for irq_pend_latch: per-bit behavioural model compared
// every cycle, plus directed literal checks.
module tb_irq_pend_latch;

`ifdef IRQ_SYNC_EN
  localparam int LAT  = 3;
  localparam bit SYNC = 1'b1;
`else
  localparam int LAT  = 1;
  localparam bit SYNC = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_in;
  logic       ack;
  logic [2:0] ack_id;
  logic [7:0] pend_out;
  logic       irq_valid;
  logic [7:0] mask_q;
  logic [7:0] ovr_cnt;

  int checks   = 0;
  int failures = 0;

  irq_pend_latch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask_wr   (mask_wr),
    .mask_in   (mask_in),
    .ack       (ack),
    .ack_id    (ack_id),
    .pend_out  (pend_out),
    .irq_valid (irq_valid),
    .mask_q    (mask_q),
    .ovr_cnt   (ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // downstream 8-to-3 priority encoder: index of highest set bit
  function automatic int enc(input logic [7:0] v);
    int y;
    y = 0;
    for (int i = 0; i < 8; i++) if (v[i]) y = i;
    return y;
  endfunction

  // behavioural model: per-line event bookkeeping
  bit [7:0] m_pend, m_mask, m_prev, m_h1, m_h2;
  int       m_ovr;

  always @(posedge clk or negedge rst_n) begin : model
    bit [7:0] s;
    bit [7:0] p;
    int       o;
    bit       rising, acked;
    if (!rst_n) begin
      m_pend <= 8'h00; m_mask <= 8'h00; m_prev <= 8'h00;
      m_h1   <= 8'h00; m_h2   <= 8'h00; m_ovr  <= 0;
    end else begin
      s = SYNC ? m_h2 : irq_in;
      p = m_pend;
      o = m_ovr;
      for (int i = 0; i < 8; i++) begin
        rising = s[i] && !m_prev[i];
        acked  = ack && (int'(ack_id) == i);
        if (rising && m_pend[i] && !acked && o < 255) o = o + 1;
        if (rising) p[i] = 1'b1;
        else if (acked) p[i] = 1'b0;
      end
      m_pend <= p;
      m_ovr  <= o;
      m_prev <= s;
      m_h2   <= m_h1;
      m_h1   <= irq_in;
      if (mask_wr) m_mask <= mask_in;
    end
  end

  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pend_out", {24'd0, pend_out}, {24'd0, m_pend & ~m_mask});
      chk("irq_valid", {31'd0, irq_valid}, {31'd0, |(m_pend & ~m_mask)});
      chk("mask_q", {24'd0, mask_q}, {24'd0, m_mask});
      chk("ovr_cnt", {24'd0, ovr_cnt}, m_ovr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ack(input logic [2:0] id);
    ack = 1'b1; ack_id = id;
    cyc(1);
    ack = 1'b0;
  endtask

  task automatic do_mask(input logic [7:0] m);
    mask_wr = 1'b1; mask_in = m;
    cyc(1);
    mask_wr = 1'b0;
  endtask

  int lat_seen;

  initial begin
    rst_n = 1'b0; irq_in = 8'h00; mask_wr = 1'b0; mask_in = 8'h00;
    ack = 1'b0; ack_id = 3'd0;
    cyc(3);
    chk("reset_pend_out", {24'd0, pend_out}, 32'h0);
    chk("reset_ovr_cnt", {24'd0, ovr_cnt}, 32'h0);
    rst_n = 1'b1;
    cyc(2);

    // case 1: two lines rise together
    irq_in = 8'h24;
    cyc(LAT);
    chk("c1_pend_out", {24'd0, pend_out}, 32'h24);
    chk("c1_irq_valid", {31'd0, irq_valid}, 32'h1);
    chk("c1_y", enc(pend_out), 32'd5);

    // case 2: service in priority order
    do_ack(3'd5);
    chk("c2_pend_out_a", {24'd0, pend_out}, 32'h04);
    chk("c2_y", enc(pend_out), 32'd2);
    do_ack(3'd2);
    chk("c2_pend_out_b", {24'd0, pend_out}, 32'h00);
    chk("c2_irq_valid", {31'd0, irq_valid}, 32'h0);
    do_ack(3'd6);
    chk("c2_ack_idle", {24'd0, pend_out}, 32'h00);

    // case 3: masked line latches but stays hidden until unmasked
    do_mask(8'h80);
    chk("c3_mask_q", {24'd0, mask_q}, 32'h80);
    irq_in = 8'hA4;
    cyc(LAT + 1);
    chk("c3_hidden", {24'd0, pend_out}, 32'h00);
    do_mask(8'h00);
    chk("c3_unmask", {24'd0, pend_out}, 32'h80);
    do_ack(3'd7);
    irq_in = 8'h00;
    cyc(LAT + 1);

    // case 4: overrun, then edge coinciding with ack
    irq_in = 8'h08;
    cyc(LAT);
    chk("c4_pend", {24'd0, pend_out}, 32'h08);
    irq_in = 8'h00; cyc(1);
    irq_in = 8'h08;
    cyc(LAT);
    chk("c4_ovr_one", {24'd0, ovr_cnt}, 32'd1);
    irq_in = 8'h00; cyc(1);
    irq_in = 8'h08;
    cyc(LAT - 1);
    do_ack(3'd3);
    chk("c4_set_wins", {24'd0, pend_out}, 32'h08);
    chk("c4_ovr_same", {24'd0, ovr_cnt}, 32'd1);
    do_ack(3'd3);
    irq_in = 8'h00;
    cyc(LAT + 1);

    // case 5: saturation
    for (int n = 0; n < 300; n++) begin
      irq_in = 8'h01; cyc(1);
      irq_in = 8'h00; cyc(1);
    end
    cyc(LAT);
    chk("c5_sat", {24'd0, ovr_cnt}, 32'hFF);
    mask_wr = 1'b1; mask_in = 8'h01; ack = 1'b1; ack_id = 3'd0;
    cyc(1);
    mask_wr = 1'b0; ack = 1'b0;
    chk("c5_mask_and_ack", {24'd0, mask_q}, 32'h01);
    do_mask(8'h00);
    chk("c5_ack_took", {24'd0, pend_out}, 32'h00);

    // case 6: asynchronous reset mid-cycle
    irq_in = 8'hFF;
    cyc(LAT);
    chk("c6_all_pend", {24'd0, pend_out}, 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("c6_rst_pend_out", {24'd0, pend_out}, 32'h0);
    chk("c6_rst_irq_valid", {31'd0, irq_valid}, 32'h0);
    chk("c6_rst_mask_q", {24'd0, mask_q}, 32'h0);
    chk("c6_rst_ovr_cnt", {24'd0, ovr_cnt}, 32'h0);
    irq_in = 8'h00;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // latency of case 1 after reset
    irq_in = 8'h24;
    lat_seen = 0;
    for (int n = 1; n <= 6; n++) begin
      cyc(1);
      if (lat_seen == 0 && pend_out == 8'h24) lat_seen = n;
    end
    chk("c6_latency", lat_seen, LAT);
    chk("c6_pend_out", {24'd0, pend_out}, 32'h24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_pend_latch.md
# irq_pend_latch

Upstream front end for the 8-to-3 priority encoder. Captures rising edges on eight asynchronous request lines into a sticky pending register, applies a software mask, and drives the masked pending vector straight into the encoder's `i` input. The consumer clears serviced requests with an acknowledge carrying the encoder's 3-bit `y` index, closing the request→encode→service loop.

## Interface
- `N`, 8, number of request lines. The encoder is fixed at 8, so only 8 is supported.
- `ID_W`, 3, width of the acknowledge index; equals log2(N).
- `clk`  input  1  single system clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is used synchronously to `clk`.
- `irq_in`  input  N  raw request lines; a rising edge is an event.
- `mask_wr`  input  1  load `mask_in` into the mask register this cycle.
- `mask_in`  input  N  new mask value; bit = 1 blocks that line.
- `ack`  input  1  clear one pending bit this cycle.
- `ack_id`  input  ID_W  index of the bit to clear; normally the encoder output `y`.
- `pend_out`  output  N  registered pending & ~mask; connects to encoder `i`.
- `irq_valid`  output  1  registered; equals |pend_out.
- `mask_q`  output  N  current mask register.
- `ovr_cnt`  output  8  saturating count of lost events.

## Operation
- Edge detect: `edge = s & ~s_prev`, where `s` is the sampled `irq_in` and `s_prev` is `s` delayed one cycle.
- Pending register:
  - A bit sets on `edge`.
  - A bit clears on `ack` when `ack_id` addresses that bit.
- Set-wins rule: if an edge and an ack hit the same bit in the same cycle, the bit stays set. The new event is retained.
- Masked lines still latch into the pending register; they are only hidden from `pend_out`. Unmasking a pending bit makes it visible on the next cycle.
- Overrun: an edge arriving on a bit that is already pending (and not being acked that cycle) increments `ovr_cnt`.
  - Multiple overruns in one cycle add their popcount.
  - The counter saturates at 255 and clears only on reset.
- An ack to a bit that is not pending has no effect.
- `mask_wr` and `ack` in the same cycle are independent and both take effect.
- Reset values:
  - pending = 0, `s_prev` = 0, mask = 8'h00 (all enabled), `ovr_cnt` = 0.
  - `pend_out` = 0, `irq_valid` = 0, `mask_q` = 0.
- Because `s_prev` resets to 0, a line held high through reset release registers one event.

## Timing
- Latency, macro off: a rising edge sampled at clock edge k sets pending at k+1. `pend_out` and `irq_valid` update at edge k+1.
- Latency, macro on: add 2 cycles, so the update lands at k+3.
- Ack at edge k: the bit drops from `pend_out` at k+1. The encoder's `y` then moves to the next-highest pending line in the same cycle (it is combinational downstream).
- `mask_wr` at edge k: `mask_q` and `pend_out` reflect the new mask at k+1.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Events in the synchronizer are discarded.
- Pulses shorter than one clock period, or a low time under one period, may be missed. This is a documented limitation, not an error.

## Configuration
- `IRQ_SYNC_EN` defined: every `irq_in` bit passes through a 2-flop synchronizer before edge detection. The synchronizer flops reset to 0.
- `IRQ_SYNC_EN` undefined: `irq_in` feeds edge detection directly. The upstream source is then required to be synchronous to `clk`.

## Structure
- Shared package `irq_pkg`:
  - `IRQ_N` = 8 and `IRQ_ID_W` = 3.
  - `irq_vec_t` (logic [7:0]) and `irq_id_t` (logic [2:0]).
  - `OVR_MAX` = 8'hFF.
- One sub-module, `irq_edge_det`, holding the optional synchronizer, `s_prev`, and the `edge` output. Instantiated once, N bits wide.
- Top level holds the pending, mask and overrun logic.

## Test plan
1. Reset, then `irq_in` = 8'h00 → 8'h24 at edge k → at k+1 `pend_out` = 8'h24 and `irq_valid` = 1. The encoder reports `y` = 5.
2. `ack` with `ack_id` = 5 → `pend_out` = 8'h04 and `y` = 2 next cycle. Then `ack` with `ack_id` = 2 → `pend_out` = 0 and `irq_valid` = 0.
3. `mask_wr` with `mask_in` = 8'h80, then an edge on bit 7 → `pend_out` stays 0 while the internal pending bit is set. Writing mask = 8'h00 → `pend_out` = 8'h80 next cycle.
4. Bit 3 pending, then a new edge on bit 3 with no ack → `ovr_cnt` = 1. Edge on bit 3 plus `ack_id` = 3 in the same cycle → bit 3 stays set and `ovr_cnt` is unchanged.
5. Drive 300 overruns on bit 0 → `ovr_cnt` holds at 8'hFF.
6. `rst_n` low asynchronously mid-stream with `pend_out` = 8'hFF → all outputs 0 before the next `clk` edge. With `IRQ_SYNC_EN` defined, rerun case 1 → `pend_out` = 8'h24 at k+3.
